weight_stream_dot_accumulator: RTL

Downstream consumer of a weight-source stream; core of a fixed-point linear layer.
Joins one activation beat (PARALLELISM lanes) with one weight beat (PARALLELISM lanes), multiplies lane-wise and reduces the products to a beat sum.
Accumulates the beat sums over IN_DEPTH beats and emits one signed dot-product result per IN_DEPTH accepted beats on a valid/ready output.
Tolerates a producer whose valid is permanently high.

---
 rtl/dot_accum_pkg.sv | 33 +++
 rtl/fixed_adder_tree.sv | 47 ++++
 rtl/weight_stream_dot_accumulator.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dot_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dot_accum_pkg
// Description : Shared width helpers and default precisions for the
//               fixed-point linear-layer dot-product blocks.
// Contents    : out_width() - result width of a PAR-lane, DEPTH-beat dot
//                             product that can never overflow
//               out_frac()  - fractional bits of a product
//               DEFAULT_*   - default lane count, depth and precisions
// Revision    : 1.0 - initial release
// ============================================================================
package dot_accum_pkg;

    localparam int DEFAULT_PARALLELISM          = 4;
    localparam int DEFAULT_IN_DEPTH             = 8;
    localparam int DEFAULT_DATA_IN_PRECISION_0  = 16;
    localparam int DEFAULT_DATA_IN_PRECISION_1  = 3;
    localparam int DEFAULT_WEIGHT_PRECISION_0   = 16;
    localparam int DEFAULT_WEIGHT_PRECISION_1   = 3;

    // Product width plus one growth bit per doubling of lanes and of beats.
    function automatic int out_width(input int din_w, input int w_w,
                                     input int par, input int depth);
        return din_w + w_w + $clog2(par) + $clog2(depth);
    endfunction

    // Binary points add under multiplication; summation does not move them.
    function automatic int out_frac(input int din_f, input int w_f);
        return din_f + w_f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_adder_tree.sv
`default_nettype none
// ============================================================================
// Module      : fixed_adder_tree
// Description : Combinational signed adder tree. Reduces IN_SIZE signed
//               operands to one sum, growing one bit per tree level so the
//               result can never overflow.
// Ports       : data_in  [IN_WIDTH-1:0] x IN_SIZE   signed operands
//               data_out [IN_WIDTH+$clog2(IN_SIZE)-1:0]  signed sum
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_adder_tree #(
    parameter int IN_SIZE  = 4,
    parameter int IN_WIDTH = 32
) (
    input  logic signed [IN_WIDTH-1:0]                  data_in [IN_SIZE],
    output logic signed [IN_WIDTH+$clog2(IN_SIZE)-1:0]  data_out
);

    localparam int LEVELS    = $clog2(IN_SIZE);
    localparam int LEAVES    = 1 << LEVELS;
    localparam int OUT_WIDTH = IN_WIDTH + LEVELS;

    // Heap-ordered binary tree: node 0 is the root, leaves occupy
    // LEAVES-1 .. 2*LEAVES-2, children of node i are 2i+1 and 2i+2.
    // Every node carries the full output width; synthesis trims the
    // unused upper bits of the lower levels.
    logic signed [OUT_WIDTH-1:0] node [0:2*LEAVES-2];

    generate
        for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
            if (j < IN_SIZE) begin : g_used
                assign node[LEAVES-1+j] = OUT_WIDTH'(data_in[j]);
            end else begin : g_pad
                // Non-power-of-two sizes are padded with zeros.
                assign node[LEAVES-1+j] = '0;
            end
        end

        for (genvar i = 0; i < LEAVES-1; i++) begin : g_node
            assign node[i] = node[2*i+1] + node[2*i+2];
        end
    endgenerate

    assign data_out = node[0];

endmodule
`default_nettype wire

// File: rtl/weight_stream_dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : weight_stream_dot_accumulator
// Description : Joins an activation beat with a weight beat, multiplies the
//               lanes, reduces them to a beat sum and accumulates IN_DEPTH
//               beats into one signed dot-product result.
// Ports       : clk, rst                      clock, sync active-high reset
//               data_in / data_in_valid / data_in_ready   activation stream
//               weight  / weight_valid  / weight_ready    weight stream
//               data_out / data_out_valid / data_out_ready result stream
// Revision    : 1.0 - initial release
// ============================================================================
module weight_stream_dot_accumulator
    import dot_accum_pkg::*;
#(
    parameter int PARALLELISM          = DEFAULT_PARALLELISM,
    parameter int IN_DEPTH             = DEFAULT_IN_DEPTH,
    parameter int DATA_IN_PRECISION_0  = DEFAULT_DATA_IN_PRECISION_0,
    parameter int DATA_IN_PRECISION_1  = DEFAULT_DATA_IN_PRECISION_1,
    parameter int WEIGHT_PRECISION_0   = DEFAULT_WEIGHT_PRECISION_0,
    parameter int WEIGHT_PRECISION_1   = DEFAULT_WEIGHT_PRECISION_1,
    parameter int DATA_OUT_PRECISION_0 = out_width(DATA_IN_PRECISION_0, WEIGHT_PRECISION_0,
                                                   PARALLELISM, IN_DEPTH),
    parameter int DATA_OUT_PRECISION_1 = out_frac(DATA_IN_PRECISION_1, WEIGHT_PRECISION_1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic signed [DATA_IN_PRECISION_0-1:0]  data_in [PARALLELISM],
    input  logic                                   data_in_valid,
    output logic                                   data_in_ready,
    input  logic signed [WEIGHT_PRECISION_0-1:0]   weight [PARALLELISM],
    input  logic                                   weight_valid,
    output logic                                   weight_ready,
    output logic signed [DATA_OUT_PRECISION_0-1:0] data_out,
    output logic                                   data_out_valid,
    input  logic                                   data_out_ready
);

    localparam int PROD_WIDTH = DATA_IN_PRECISION_0 + WEIGHT_PRECISION_0;
    localparam int SUM_WIDTH  = PROD_WIDTH + $clog2(PARALLELISM);
    localparam int CNT_WIDTH  = $clog2(IN_DEPTH) + 1;

    // The result width and binary point are derived; reject overrides that
    // would break the no-overflow guarantee.
    generate
        if (IN_DEPTH < 1) begin : g_bad_depth
            $error("IN_DEPTH must be at least 1");
        end
        if (DATA_OUT_PRECISION_0 != out_width(DATA_IN_PRECISION_0, WEIGHT_PRECISION_0,
                                              PARALLELISM, IN_DEPTH)) begin : g_bad_width
            $error("DATA_OUT_PRECISION_0 is derived and must not be overridden");
        end
        if (DATA_OUT_PRECISION_1 != out_frac(DATA_IN_PRECISION_1,
                                             WEIGHT_PRECISION_1)) begin : g_bad_frac
            $error("DATA_OUT_PRECISION_1 is derived and must not be overridden");
        end
    endgenerate

    logic signed [PROD_WIDTH-1:0]           product [PARALLELISM];
    logic signed [SUM_WIDTH-1:0]            beat_sum;
    logic signed [DATA_OUT_PRECISION_0-1:0] beat_sum_ext;
    logic signed [DATA_OUT_PRECISION_0-1:0] acc;
    logic signed [DATA_OUT_PRECISION_0-1:0] acc_next;
    logic        [CNT_WIDTH-1:0]            beat_cnt;
    logic                                   is_last;
    logic                                   out_free;
    logic                                   can_accept;
    logic                                   fire;

    generate
        for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
            assign product[i] = data_in[i] * weight[i];
        end
    endgenerate

    // Summing at product width and sign-extending afterwards is numerically
    // identical to extending each product first, and keeps the tree narrow.
    fixed_adder_tree #(
        .IN_SIZE  (PARALLELISM),
        .IN_WIDTH (PROD_WIDTH)
    ) u_adder_tree (
        .data_in  (product),
        .data_out (beat_sum)
    );

    assign beat_sum_ext = DATA_OUT_PRECISION_0'(beat_sum);
    assign acc_next     = acc + beat_sum_ext;

    // Only the last beat needs a free output slot; earlier beats only touch
    // the accumulator and keep flowing under output backpressure.
    assign is_last    = (beat_cnt == CNT_WIDTH'(IN_DEPTH - 1));
    assign out_free   = !data_out_valid || data_out_ready;
    assign can_accept = !is_last || out_free;

    // Each ready depends on the other stream's valid so that the two streams
    // are always consumed together.
    assign data_in_ready = weight_valid && can_accept;
    assign weight_ready  = data_in_valid && can_accept;
    assign fire          = data_in_valid && weight_valid && can_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt       <= '0;
            acc            <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end
            if (fire) begin
                if (is_last) begin
                    // Overrides the clear above so back-to-back results
                    // leave no bubble.
                    data_out       <= acc_next;
                    data_out_valid <= 1'b1;
                    acc            <= '0;
                    beat_cnt       <= '0;
                end else begin
                    acc            <= acc_next;
                    beat_cnt       <= beat_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
